banco_registros_param: RTL

Parametrised successor to the processor's integer register file. Two combinational read ports and one synchronous write port, with register 0 hard-wired to zero. Adds a range soft-clear engine that zeroes a contiguous register window, one register per cycle, through a handshake. Sits between decode (read addresses) and writeback (rd/di/wre) in the datapath.

---
 rtl/banco_registros_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/banco_registros_param.sv
// Parametrised integer register file: two combinational read ports, one write port and a
// range soft-clear engine. Optional write-to-read forwarding under macro BANCO_REG_BYPASS_EN.
module banco_registros_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] do1,
   output logic [DATA_W-1:0] do2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] di,
   input  logic              wre,
   output logic              wr_rdy,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] clr_lo,
   input  logic [ADDR_W-1:0] clr_hi,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int NREG = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W-1:0] ptr_s;
   logic [ADDR_W-1:0] hi_r;
   logic [ADDR_W-1:0] hi_s;
   logic              wr_rdy_r;
   logic              clr_busy_r;
   logic              clr_done_r;
   logic              wr_keep_s;
   logic [DATA_W-1:0] regs_r [NREG];

   // A write commits only when accepted and not aimed at a hard-wired zero register.
   assign wr_keep_s = wre && wr_rdy_r &&
                      ((ZERO_REG == 0) || (rd != {ADDR_W{1'b0}}));

   // Clear engine next-state logic.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      hi_s    = hi_r;
      case (state_r)
         IDLE: begin
            if (clr_req) begin
               ptr_s = clr_lo;
               hi_s  = clr_hi;
               if (clr_lo > clr_hi) begin
                  state_s = DONE;
               end else begin
                  state_s = CLEAR;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CLEAR: begin
            if (ptr_r == hi_r) begin
               state_s = DONE;
            end else begin
               ptr_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_s = CLEAR;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; status outputs are registered from the next state.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state_r    <= IDLE;
         ptr_r      <= {ADDR_W{1'b0}};
         hi_r       <= {ADDR_W{1'b0}};
         wr_rdy_r   <= 1'b1;
         clr_busy_r <= 1'b0;
         clr_done_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         hi_r       <= hi_s;
         wr_rdy_r   <= (state_s != CLEAR);
         clr_busy_r <= (state_s == CLEAR);
         clr_done_r <= (state_s == DONE);
      end
   end

   // Register storage; writes and sweep never coincide since wr_rdy is low in CLEAR.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (wr_keep_s) begin
            regs_r[rd] <= di;
         end
         if (state_r == CLEAR) begin
            regs_r[ptr_r] <= {DATA_W{1'b0}};
         end
      end
   end

   // Combinational read ports.
   always_comb begin
      do1 = regs_r[rs1];
      do2 = regs_r[rs2];
`ifdef BANCO_REG_BYPASS_EN
      do1 = (wr_keep_s && (rs1 == rd)) ? di : regs_r[rs1];
      do2 = (wr_keep_s && (rs2 == rd)) ? di : regs_r[rs2];
`endif
      do1 = ((ZERO_REG != 0) && (rs1 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : do1;
      do2 = ((ZERO_REG != 0) && (rs2 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : do2;
   end

   assign wr_rdy   = wr_rdy_r;
   assign clr_busy = clr_busy_r;
   assign clr_done = clr_done_r;

endmodule
